// File: rtl/cmos_dvp_tx_pkg.sv
// Shared definitions for the DVP test-pattern transmitter: pattern codes,
// colour-bar palette and timing FSM encoding.
package cmos_dvp_tx_pkg;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pat_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBP    = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFP    = 3'd4
   } dvp_state_e;

   localparam logic [15:0] BAR_C0 = 16'hFFFF;
   localparam logic [15:0] BAR_C1 = 16'hFFE0;
   localparam logic [15:0] BAR_C2 = 16'h07FF;
   localparam logic [15:0] BAR_C3 = 16'h07E0;
   localparam logic [15:0] BAR_C4 = 16'hF81F;
   localparam logic [15:0] BAR_C5 = 16'hF800;
   localparam logic [15:0] BAR_C6 = 16'h001F;
   localparam logic [15:0] BAR_C7 = 16'h0000;

   // Index 8 and above marks the leftover pixels right of the last full bar.
   function automatic logic [15:0] bar_color(input logic [3:0] idx);
      logic [15:0] c;
      c = 16'h0000;
      if (!idx[3]) begin
         case (idx[2:0])
            3'd0: c = BAR_C0;
            3'd1: c = BAR_C1;
            3'd2: c = BAR_C2;
            3'd3: c = BAR_C3;
            3'd4: c = BAR_C4;
            3'd5: c = BAR_C5;
            3'd6: c = BAR_C6;
            default: c = BAR_C7;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/dvp_pattern_rom.sv
// Combinational RGB565 pixel generator for the built-in test patterns.
module dvp_pattern_rom
   import cmos_dvp_tx_pkg::*;
(
   input  pat_e        pattern,
   input  logic [4:0]  x,
   input  logic [5:0]  y,
   input  logic [3:0]  bar_idx,
   input  logic [4:0]  frame_cnt,
   input  logic [15:0] solid,
   output logic [15:0] pixel
);

   always_comb begin
      pixel = 16'h0000;
      case (pattern)
         PAT_BARS:  pixel = bar_color(bar_idx);
         PAT_RAMP:  pixel = {x, y, frame_cnt};
         PAT_CHECK: pixel = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
         PAT_SOLID: pixel = solid;
         default:   pixel = 16'h0000;
      endcase
   end

endmodule

// File: rtl/cmos_dvp_tx.sv
// DVP camera-side transmitter: OV5640-style vsync/href/byte stream carrying
// RGB565 test patterns, timed by a frame FSM with registered outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | stopped, waiting for en
// ST_VSYNC  | VS_LINES line periods with vsync high
// ST_VBP    | V_BP idle line periods before the first active line
// ST_ACTIVE | V_DISP lines: 2*H_DISP bytes with href, then H_BLANK gap
// ST_VFP    | V_FP idle line periods; en decides restart or idle
module cmos_dvp_tx
   import cmos_dvp_tx_pkg::*;
#(
   parameter int H_DISP   = 480,
   parameter int V_DISP   = 272,
   parameter int H_BLANK  = 64,
   parameter int VS_LINES = 2,
   parameter int V_BP     = 4,
   parameter int V_FP     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  pattern,
   input  logic [15:0] solid_color,
   output logic        cmos_vsync,
   output logic        cmos_href,
   output logic [7:0]  cmos_data,
   output logic        frame_done,
   output logic        busy,
   output logic [7:0]  frame_cnt
);

   localparam int          L       = 2 * H_DISP + H_BLANK;
   localparam int          BW      = H_DISP / 8;
   localparam logic [15:0] H_LAST  = 16'(L - 1);
   localparam logic [15:0] H_ACT   = 16'(2 * H_DISP);
   localparam logic [15:0] BW_LAST = 16'(BW - 1);

   dvp_state_e  state_q, state_d;
   logic [15:0] hcnt_q, hcnt_d;
   logic [15:0] line_q, line_d;
   logic [15:0] x_q, x_d;
   logic [15:0] bar_cnt_q, bar_cnt_d;
   logic [3:0]  bar_idx_q, bar_idx_d;
   pat_e        pat_q, pat_d;
   logic [15:0] solid_q, solid_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;

   logic        vsync_q, vsync_d;
   logic        href_q, href_d;
   logic [7:0]  data_q, data_d;
   logic        frame_done_q, frame_done_d;
   logic        busy_q, busy_d;

   logic        line_end, last_line, state_end;
   logic        frame_start, frame_end, href_w, pix_step;
   logic [15:0] pixel;

   always_comb begin
      line_end  = (hcnt_q == H_LAST);
      last_line = 1'b0;
      case (state_q)
         ST_VSYNC:  last_line = (line_q == 16'(VS_LINES - 1));
         ST_VBP:    last_line = (line_q == 16'(V_BP - 1));
         ST_ACTIVE: last_line = (line_q == 16'(V_DISP - 1));
         ST_VFP:    last_line = (line_q == 16'(V_FP - 1));
         default:   last_line = 1'b0;
      endcase
      state_end   = line_end && last_line;
      frame_end   = (state_q == ST_VFP) && state_end;
      frame_start = en && ((state_q == ST_IDLE) || frame_end);
      href_w      = (state_q == ST_ACTIVE) && (hcnt_q < H_ACT);
      pix_step    = href_w && hcnt_q[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (en)        state_d = ST_VSYNC;
         ST_VSYNC:  if (state_end) state_d = ST_VBP;
         ST_VBP:    if (state_end) state_d = ST_ACTIVE;
         ST_ACTIVE: if (state_end) state_d = ST_VFP;
         ST_VFP:    if (state_end) state_d = en ? ST_VSYNC : ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hcnt_d      = hcnt_q;
      line_d      = line_q;
      x_d         = x_q;
      bar_cnt_d   = bar_cnt_q;
      bar_idx_d   = bar_idx_q;
      pat_d       = pat_q;
      solid_d     = solid_q;
      frame_cnt_d = frame_cnt_q;

      if (state_q == ST_IDLE) begin
         hcnt_d = 16'd0;
         line_d = 16'd0;
      end else begin
         hcnt_d = line_end ? 16'd0 : hcnt_q + 16'd1;
         if (state_end)     line_d = 16'd0;
         else if (line_end) line_d = line_q + 16'd1;
      end

      // Bar position tracked incrementally so no divide by BW is needed.
      if ((state_q != ST_ACTIVE) || line_end) begin
         x_d       = 16'd0;
         bar_cnt_d = 16'd0;
         bar_idx_d = 4'd0;
      end else if (pix_step) begin
         x_d = x_q + 16'd1;
         if (bar_cnt_q == BW_LAST) begin
            bar_cnt_d = 16'd0;
            if (!bar_idx_q[3]) bar_idx_d = bar_idx_q + 4'd1;
         end else begin
            bar_cnt_d = bar_cnt_q + 16'd1;
         end
      end

      if (frame_start) begin
         pat_d   = pat_e'(pattern);
         solid_d = solid_color;
      end
      if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
   end

   dvp_pattern_rom u_rom (
      .pattern   (pat_q),
      .x         (x_q[4:0]),
      .y         (line_q[5:0]),
      .bar_idx   (bar_idx_q),
      .frame_cnt (frame_cnt_q[4:0]),
      .solid     (solid_q),
      .pixel     (pixel)
   );

   always_comb begin
      vsync_d      = (state_q == ST_VSYNC);
      href_d       = href_w;
      data_d       = href_w ? (hcnt_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
      frame_done_d = frame_end;
      busy_d       = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q       <= 16'd0;
         line_q       <= 16'd0;
         x_q          <= 16'd0;
         bar_cnt_q    <= 16'd0;
         bar_idx_q    <= 4'd0;
         pat_q        <= PAT_BARS;
         solid_q      <= 16'h0000;
         frame_cnt_q  <= 8'd0;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         data_q       <= 8'h00;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         hcnt_q       <= hcnt_d;
         line_q       <= line_d;
         x_q          <= x_d;
         bar_cnt_q    <= bar_cnt_d;
         bar_idx_q    <= bar_idx_d;
         pat_q        <= pat_d;
         solid_q      <= solid_d;
         frame_cnt_q  <= frame_cnt_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign cmos_vsync = vsync_q;
   assign cmos_href  = href_q;
   assign cmos_data  = data_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Directed bench for cmos_dvp_tx with a reduced 16x4 frame (L = 36) and a
// 32-pixel-wide instance for the checkerboard edge.
module tb_cmos_dvp_tx;

   localparam int HD = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  pattern = 2'd0;
   logic [15:0] solid_color = 16'h0000;
   logic        cmos_vsync, cmos_href, frame_done, busy;
   logic [7:0]  cmos_data, frame_cnt;

   logic        en32 = 1'b0;
   logic [1:0]  pattern32 = 2'd2;
   logic [15:0] solid32 = 16'h0000;
   logic        vsync32, href32, frame_done32, busy32;
   logic [7:0]  data32, frame_cnt32;

   always #5 clk = ~clk;

   cmos_dvp_tx #(.H_DISP(16), .V_DISP(4), .H_BLANK(4), .VS_LINES(1), .V_BP(1), .V_FP(1)) dut (
      .clk(clk), .rst(rst), .en(en), .pattern(pattern), .solid_color(solid_color),
      .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
      .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt)
   );

   cmos_dvp_tx #(.H_DISP(32), .V_DISP(4), .H_BLANK(4), .VS_LINES(1), .V_BP(1), .V_FP(1)) dut32 (
      .clk(clk), .rst(rst), .en(en32), .pattern(pattern32), .solid_color(solid32),
      .cmos_vsync(vsync32), .cmos_href(href32), .cmos_data(data32),
      .frame_done(frame_done32), .busy(busy32), .frame_cnt(frame_cnt32)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] cap [0:255];
   int nb, nh, ovl, dnz, first_href, bad_len;

   logic [7:0]  exp_bars [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0, 8'h07, 8'hFF};
   logic [15:0] bar_tbl  [8]  = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic wait_vs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (cmos_vsync) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called on the sample where vsync has just risen (clock 1 of the frame).
   task automatic capture_frame(output int fd_at);
      bit prev;
      int run;
      nb = 0; nh = 0; ovl = 0; dnz = 0; first_href = -1; bad_len = 0;
      prev = 1'b0; run = 0; fd_at = -1;
      for (int c = 1; c <= 600; c++) begin
         if (cmos_vsync && cmos_href) ovl++;
         if (cmos_href) begin
            if (!prev) begin
               nh++;
               if (first_href < 0) first_href = c;
            end
            run++;
            if (nb < 256) begin
               cap[nb] = cmos_data;
               nb++;
            end
         end else begin
            if (prev && run != 2 * HD) bad_len++;
            run = 0;
            if (cmos_data != 8'h00) dnz++;
         end
         prev = cmos_href;
         if (frame_done) begin
            fd_at = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   function automatic logic [7:0] bar_byte(input int i);
      logic [15:0] c;
      int x;
      x = (i % (2 * HD)) / 2;
      c = bar_tbl[x / 2];
      return (i % 2 == 0) ? c[15:8] : c[7:0];
   endfunction

   function automatic logic [7:0] ramp_byte(input int i, input int fc);
      logic [15:0] p;
      int x, y;
      y = i / (2 * HD);
      x = (i % (2 * HD)) / 2;
      p = 16'(((x & 31) << 11) | ((y & 63) << 5) | (fc & 31));
      return (i % 2 == 0) ? p[15:8] : p[7:0];
   endfunction

   task automatic frame_checks(input string tag, input int fd_at);
      chk({tag, "_fd_clk"}, fd_at, 252);
      chk({tag, "_nbytes"}, nb, 128);
      chk({tag, "_nhref"}, nh, 4);
      chk({tag, "_line_len"}, bad_len, 0);
      chk({tag, "_vs_href"}, ovl, 0);
      chk({tag, "_data_blank"}, dnz, 0);
   endtask

   initial begin
      bit ok;
      int fd_at, errs, any;

      // 1: reset and idle
      #12;
      chk("rst_vsync", cmos_vsync, 0);
      chk("rst_href", cmos_href, 0);
      chk("rst_data", cmos_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fcnt", frame_cnt, 0);
      @(negedge clk); rst = 1'b0;
      any = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmos_vsync || cmos_href || cmos_data != 0 || frame_done || busy || frame_cnt != 0) any++;
      end
      chk("idle_quiet", any, 0);

      // 2: colour bars
      pattern = 2'd0; en = 1'b1;
      @(negedge clk);
      chk("start_vs_lat0", cmos_vsync, 0);
      @(negedge clk);
      chk("start_vs_lat1", cmos_vsync, 1);
      chk("start_busy", busy, 1);
      capture_frame(fd_at);
      frame_checks("bars", fd_at);
      chk("bars_first_href", first_href, 73);
      for (int i = 0; i < 10; i++) chk($sformatf("bars_b%0d", i), cap[i], exp_bars[i]);
      errs = 0;
      for (int i = 0; i < nb; i++) if (cap[i] !== bar_byte(i)) errs++;
      chk("bars_all", errs, 0);
      chk("bars_fcnt", frame_cnt, 1);

      rst = 1'b1; en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 4: solid, three frames back to back
      pattern = 2'd3; solid_color = 16'h1234; en = 1'b1;
      wait_vs(ok);
      chk("solid_vs", ok, 1);
      for (int f = 0; f < 3; f++) begin
         capture_frame(fd_at);
         frame_checks($sformatf("solid%0d", f), fd_at);
         errs = 0;
         for (int i = 0; i < nb; i++) if (cap[i] !== ((i % 2 == 0) ? 8'h12 : 8'h34)) errs++;
         chk($sformatf("solid%0d_bytes", f), errs, 0);
         chk($sformatf("solid%0d_fcnt", f), frame_cnt, f + 1);
         @(negedge clk);
         chk($sformatf("solid%0d_b2b_vs", f), cmos_vsync, 1);
      end

      // 5: change pattern and drop en mid-frame
      pattern = 2'd0; solid_color = 16'h0000; en = 1'b0;
      capture_frame(fd_at);
      frame_checks("drop", fd_at);
      errs = 0;
      for (int i = 0; i < nb; i++) if (cap[i] !== ((i % 2 == 0) ? 8'h12 : 8'h34)) errs++;
      chk("drop_bytes", errs, 0);
      chk("drop_fcnt", frame_cnt, 4);
      repeat (2) @(negedge clk);
      chk("drop_busy", busy, 0);
      any = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmos_vsync || busy) any++;
      end
      chk("drop_stays_idle", any, 0);

      // ramp, frame_cnt = 4 during this frame
      pattern = 2'd1; en = 1'b1;
      wait_vs(ok);
      chk("ramp_vs", ok, 1);
      en = 1'b0;
      capture_frame(fd_at);
      frame_checks("ramp", fd_at);
      errs = 0;
      for (int i = 0; i < nb; i++) if (cap[i] !== ramp_byte(i, 4)) errs++;
      chk("ramp_bytes", errs, 0);
      chk("ramp_b1", cap[1], 8'h04);
      chk("ramp_b38", cap[38], 8'h18);
      chk("ramp_fcnt", frame_cnt, 5);

      // 3: checkerboard on the 32-wide instance
      en32 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (href32) begin
            ok = 1'b1;
            break;
         end
      end
      chk("chk32_href", ok, 1);
      en32 = 1'b0;
      errs = 0;
      for (int i = 0; i < 64; i++) begin
         if (!href32 || data32 !== ((i < 32) ? 8'h00 : 8'hFF)) errs++;
         @(negedge clk);
      end
      chk("chk32_bytes", errs, 0);
      chk("chk32_href_end", href32, 0);

      // 6: async reset mid active line
      pattern = 2'd3; solid_color = 16'h1234; en = 1'b1;
      wait_vs(ok);
      chk("arst_vs", ok, 1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmos_href) begin
            ok = 1'b1;
            break;
         end
      end
      chk("arst_href_seen", ok, 1);
      repeat (5) @(negedge clk);
      chk("arst_pre_href", cmos_href, 1);
      rst = 1'b1;
      #1;
      chk("arst_href", cmos_href, 0);
      chk("arst_vsync", cmos_vsync, 0);
      chk("arst_data", cmos_data, 0);
      chk("arst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_vs_lat0", cmos_vsync, 0);
      @(negedge clk);
      chk("arst_vs_lat1", cmos_vsync, 1);
      chk("arst_fcnt", frame_cnt, 0);
      en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
